// File: rtl/prl_rx_msg_ctrl.sv
// Protocol-layer receive control: GoodCRC handshake, per-SOP duplicate filter, one-entry delivery buffer.
// Define PRL_RX_DUP_CHECK_EN to build the stored-MessageID table and duplicate filtering.
module prl_rx_msg_ctrl #(
    parameter logic [7:0] GOODCRC_TO_CYC = 8'd200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prl_rx_parser_message_req,
    input  logic [1:0] prl_rx_parser_message_type,
    input  logic [2:0] prl_rx_parser_sop_type,
    input  logic [4:0] prl_rx_parser_header_type,
    input  logic [2:0] prl_rx_parser_message_id,
    input  logic       prl_rx_ctrl_clear,
    output logic       prl_rx_goodcrc_req,
    output logic [2:0] prl_rx_goodcrc_sop_type,
    output logic [2:0] prl_rx_goodcrc_message_id,
    input  logic       prl_tx_goodcrc_done,
    input  logic       prl_tx_goodcrc_fail,
    output logic       prl_rx_msg_valid,
    output logic [1:0] prl_rx_msg_type,
    output logic [4:0] prl_rx_msg_header_type,
    output logic [2:0] prl_rx_msg_sop_type,
    input  logic       pe_rx_msg_ack,
    output logic       prl_rx_msg_dropped,
    output logic       prl_rx_msg_overrun,
    output logic       prl_rx_soft_reset_det
);
    typedef enum logic [1:0] {IDLE, CHECK, GC_REQ, COMMIT} state_t;

    state_t     state, state_nxt;
    logic [2:0] cap_sop;
    logic [1:0] cap_type;
    logic [4:0] cap_hdr;
    logic [2:0] cap_id;
    logic [7:0] to_cnt;
    logic       non_sop, is_soft_reset, is_dup, to_hit;
    logic       drop_nxt, ovr_nxt, sr_nxt, load_buf;

    assign non_sop       = cap_sop >= 3'd3;
    assign is_soft_reset = (cap_type == 2'd0) && (cap_hdr == 5'h0D);
    assign to_hit        = to_cnt == (GOODCRC_TO_CYC - 8'd1);

`ifdef PRL_RX_DUP_CHECK_EN
    logic [2:0] tbl_vld;
    logic [2:0] tbl_id [3];
    logic       sel_vld;
    logic [2:0] sel_id;

    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 3'd0;
        for (int i = 0; i < 3; i++) begin
            if (cap_sop == 3'(i)) begin
                sel_vld = tbl_vld[i];
                sel_id  = tbl_id[i];
            end
        end
    end

    // Soft_Reset always resynchronises MessageIDs, so it is never treated as a repeat
    assign is_dup = sel_vld && (sel_id == cap_id) && !is_soft_reset;

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_vld <= '0;
            for (int i = 0; i < 3; i++) tbl_id[i] <= 3'd0;
        end else if (prl_rx_ctrl_clear) begin
            tbl_vld <= '0;
        end else if (state == CHECK && non_sop) begin
            tbl_vld <= '0;
        end else if (state == COMMIT && !is_dup) begin
            for (int i = 0; i < 3; i++) begin
                if (cap_sop == 3'(i)) begin
                    tbl_vld[i] <= 1'b1;
                    tbl_id[i]  <= cap_id;
                end else if (is_soft_reset) begin
                    tbl_vld[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (prl_rx_parser_message_req) state_nxt = CHECK;
            CHECK:   state_nxt = non_sop ? IDLE : GC_REQ;
            GC_REQ: begin
                if (prl_tx_goodcrc_done) state_nxt = COMMIT;
                else if (prl_tx_goodcrc_fail || to_hit) state_nxt = IDLE;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (prl_rx_ctrl_clear) state_nxt = IDLE;
    end

    always_comb begin
        prl_rx_goodcrc_req        = (state == GC_REQ);
        prl_rx_goodcrc_sop_type   = prl_rx_goodcrc_req ? cap_sop : 3'd0;
        prl_rx_goodcrc_message_id = prl_rx_goodcrc_req ? cap_id : 3'd0;
        drop_nxt = 1'b0;
        sr_nxt   = 1'b0;
        load_buf = 1'b0;
        ovr_nxt  = prl_rx_parser_message_req && (state != IDLE);
        case (state)
            CHECK:  drop_nxt = non_sop;
            GC_REQ: drop_nxt = !prl_tx_goodcrc_done && (prl_tx_goodcrc_fail || to_hit);
            COMMIT: begin
                drop_nxt = is_dup;
                load_buf = !is_dup;
                sr_nxt   = !is_dup && is_soft_reset;
            end
            default: ;
        endcase
        if (load_buf && prl_rx_msg_valid && !pe_rx_msg_ack) ovr_nxt = 1'b1;
        if (prl_rx_ctrl_clear) begin
            drop_nxt = 1'b0;
            ovr_nxt  = 1'b0;
            sr_nxt   = 1'b0;
            load_buf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_sop  <= 3'd0;
            cap_type <= 2'd0;
            cap_hdr  <= 5'd0;
            cap_id   <= 3'd0;
            to_cnt   <= 8'd0;
        end else begin
            if (state == IDLE && prl_rx_parser_message_req && !prl_rx_ctrl_clear) begin
                cap_sop  <= prl_rx_parser_sop_type;
                cap_type <= prl_rx_parser_message_type;
                cap_hdr  <= prl_rx_parser_header_type;
                cap_id   <= prl_rx_parser_message_id;
            end
            if (state == CHECK)       to_cnt <= 8'd0;
            else if (state == GC_REQ) to_cnt <= to_cnt + 8'd1;
        end
    end

    // Delivery buffer: a new load always wins over a same-cycle ack
    always_ff @(posedge clk) begin
        if (rst) begin
            prl_rx_msg_valid       <= 1'b0;
            prl_rx_msg_type        <= 2'd0;
            prl_rx_msg_header_type <= 5'd0;
            prl_rx_msg_sop_type    <= 3'd0;
        end else if (prl_rx_ctrl_clear) begin
            prl_rx_msg_valid <= 1'b0;
        end else if (load_buf) begin
            prl_rx_msg_valid       <= 1'b1;
            prl_rx_msg_type        <= cap_type;
            prl_rx_msg_header_type <= cap_hdr;
            prl_rx_msg_sop_type    <= cap_sop;
        end else if (pe_rx_msg_ack) begin
            prl_rx_msg_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prl_rx_msg_dropped    <= 1'b0;
            prl_rx_msg_overrun    <= 1'b0;
            prl_rx_soft_reset_det <= 1'b0;
        end else begin
            prl_rx_msg_dropped    <= drop_nxt;
            prl_rx_msg_overrun    <= ovr_nxt;
            prl_rx_soft_reset_det <= sr_nxt;
        end
    end
endmodule

// File: tb/tb_prl_rx_msg_ctrl.sv
// Directed bench for prl_rx_msg_ctrl; expectations follow PRL_RX_DUP_CHECK_EN when it is defined.
module tb_prl_rx_msg_ctrl;
`ifdef PRL_RX_DUP_CHECK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, req, clear, done, fail, ack;
    logic [1:0] mtype;
    logic [2:0] sop, id;
    logic [4:0] hdr;
    logic       gc_req, valid, dropped, overrun, sr_det;
    logic [2:0] gc_sop, gc_id, msg_sop;
    logic [1:0] msg_type;
    logic [4:0] msg_hdr;

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0, ovr_cnt = 0, sr_cnt = 0;

    prl_rx_msg_ctrl #(.GOODCRC_TO_CYC(8'd10)) dut (
        .clk(clk), .rst(rst),
        .prl_rx_parser_message_req(req),
        .prl_rx_parser_message_type(mtype),
        .prl_rx_parser_sop_type(sop),
        .prl_rx_parser_header_type(hdr),
        .prl_rx_parser_message_id(id),
        .prl_rx_ctrl_clear(clear),
        .prl_rx_goodcrc_req(gc_req),
        .prl_rx_goodcrc_sop_type(gc_sop),
        .prl_rx_goodcrc_message_id(gc_id),
        .prl_tx_goodcrc_done(done),
        .prl_tx_goodcrc_fail(fail),
        .prl_rx_msg_valid(valid),
        .prl_rx_msg_type(msg_type),
        .prl_rx_msg_header_type(msg_hdr),
        .prl_rx_msg_sop_type(msg_sop),
        .pe_rx_msg_ack(ack),
        .prl_rx_msg_dropped(dropped),
        .prl_rx_msg_overrun(overrun),
        .prl_rx_soft_reset_det(sr_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dropped === 1'b1) drop_cnt <= drop_cnt + 1;
        if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
        if (sr_det === 1'b1)  sr_cnt <= sr_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_msg(input [2:0] s, input [1:0] t, input [4:0] h, input [2:0] i);
        sop = s; mtype = t; hdr = h; id = i;
    endtask

    // Full receive: req, GoodCRC outcome in the first GC_REQ cycle, one cycle past the buffer load
    task automatic deliver(input [2:0] s, input [1:0] t, input [4:0] h, input [2:0] i,
                           input bit done_v, input bit fail_v, input bit ack_commit,
                           output bit gc_seen);
        set_msg(s, t, h, i);
        req = 1'b1; step(); req = 1'b0;
        step();
        gc_seen = (gc_req === 1'b1) && (gc_id === i) && (gc_sop === s);
        done = done_v; fail = fail_v; step(); done = 1'b0; fail = 1'b0;
        ack = ack_commit; step(); ack = 1'b0;
        step();
    endtask

    task automatic do_ack();
        ack = 1'b1; step(); ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        checks++; if ({gc_req, gc_sop, gc_id} !== 7'd0) begin errors++; $display("FAIL reset_goodcrc got %0h exp 0", {gc_req, gc_sop, gc_id}); end
        checks++; if ({valid, msg_type, msg_hdr, msg_sop} !== 11'd0) begin errors++; $display("FAIL reset_buffer got %0h exp 0", {valid, msg_type, msg_hdr, msg_sop}); end
        checks++; if ({dropped, overrun, sr_det} !== 3'd0) begin errors++; $display("FAIL reset_pulses got %0b exp 0", {dropped, overrun, sr_det}); end
    endtask

    task automatic test_single();
        int d0;
        d0 = drop_cnt;
        set_msg(3'd0, 2'd1, 5'd2, 3'd3);
        req = 1'b1; step(); req = 1'b0;
        checks++; if (gc_req !== 1'b0) begin errors++; $display("FAIL single_gc_t1 got %0b exp 0", gc_req); end
        step();
        checks++; if ({gc_req, gc_sop, gc_id} !== {1'b1, 3'd0, 3'd3}) begin errors++; $display("FAIL single_gc_t2 got %0h exp %0h", {gc_req, gc_sop, gc_id}, {1'b1, 3'd0, 3'd3}); end
        step(); step(); step();
        checks++; if (gc_req !== 1'b1) begin errors++; $display("FAIL single_gc_held got %0b exp 1", gc_req); end
        done = 1'b1; step(); done = 1'b0;
        checks++; if ({gc_req, valid} !== 2'b00) begin errors++; $display("FAIL single_commit got %0b exp 00", {gc_req, valid}); end
        step();
        checks++; if ({valid, msg_type, msg_hdr, msg_sop} !== {1'b1, 2'd1, 5'd2, 3'd0}) begin errors++; $display("FAIL single_deliver got %0h exp %0h", {valid, msg_type, msg_hdr, msg_sop}, {1'b1, 2'd1, 5'd2, 3'd0}); end
        do_ack();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_ack got %0b exp 0", valid); end
        step();
        checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL single_nodrop got %0d exp 0", drop_cnt - d0); end
    endtask

    task automatic test_duplicate();
        int d0;
        bit gc;
        d0 = drop_cnt;
        deliver(3'd0, 2'd1, 5'd2, 3'd3, 1'b1, 1'b0, 1'b0, gc);
        checks++; if (gc !== 1'b1) begin errors++; $display("FAIL dup_goodcrc got %0b exp 1", gc); end
        checks++; if (drop_cnt - d0 !== (DUP ? 1 : 0)) begin errors++; $display("FAIL dup_dropped got %0d exp %0d", drop_cnt - d0, DUP ? 1 : 0); end
        checks++; if (valid !== !DUP) begin errors++; $display("FAIL dup_valid got %0b exp %0b", valid, !DUP); end
        do_ack();
        deliver(3'd1, 2'd1, 5'd4, 3'd3, 1'b1, 1'b0, 1'b0, gc);
        checks++; if ({valid, msg_hdr, msg_sop} !== {1'b1, 5'd4, 3'd1}) begin errors++; $display("FAIL dup_other_sop got %0h exp %0h", {valid, msg_hdr, msg_sop}, {1'b1, 5'd4, 3'd1}); end
        do_ack();
    endtask

    task automatic test_soft_reset();
        int d0, s0;
        bit gc;
        deliver(3'd1, 2'd1, 5'd6, 3'd5, 1'b1, 1'b0, 1'b0, gc);
        do_ack();
        d0 = drop_cnt; s0 = sr_cnt;
        deliver(3'd0, 2'd0, 5'h0D, 3'd3, 1'b1, 1'b0, 1'b0, gc);
        checks++; if ({valid, msg_type, msg_hdr} !== {1'b1, 2'd0, 5'h0D}) begin errors++; $display("FAIL sr_deliver got %0h exp %0h", {valid, msg_type, msg_hdr}, {1'b1, 2'd0, 5'h0D}); end
        checks++; if (sr_cnt - s0 !== 1) begin errors++; $display("FAIL sr_pulse got %0d exp 1", sr_cnt - s0); end
        checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL sr_nodrop got %0d exp 0", drop_cnt - d0); end
        do_ack();
        deliver(3'd1, 2'd1, 5'd7, 3'd5, 1'b1, 1'b0, 1'b0, gc);
        checks++; if ({valid, msg_hdr} !== {1'b1, 5'd7}) begin errors++; $display("FAIL sr_sop1_after got %0h exp %0h", {valid, msg_hdr}, {1'b1, 5'd7}); end
        do_ack();
    endtask

    task automatic test_timeout();
        int d0, hi;
        d0 = drop_cnt; hi = 0;
        set_msg(3'd2, 2'd1, 5'd8, 3'd1);
        req = 1'b1; step(); req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (gc_req === 1'b1) hi++;
        end
        checks++; if (hi !== 10) begin errors++; $display("FAIL to_gc_cycles got %0d exp 10", hi); end
        checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL to_dropped got %0d exp 1", drop_cnt - d0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL to_valid got %0b exp 0", valid); end
        d0 = drop_cnt;
        set_msg(3'd2, 2'd1, 5'd9, 3'd4);
        req = 1'b1; step(); req = 1'b0;
        step();
        repeat (9) step();
        checks++; if (gc_req !== 1'b1) begin errors++; $display("FAIL to_last_cycle_gc got %0b exp 1", gc_req); end
        done = 1'b1; step(); done = 1'b0;
        step();
        checks++; if ({valid, msg_hdr} !== {1'b1, 5'd9}) begin errors++; $display("FAIL to_done_wins got %0h exp %0h", {valid, msg_hdr}, {1'b1, 5'd9}); end
        step();
        checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL to_done_nodrop got %0d exp 0", drop_cnt - d0); end
        do_ack();
    endtask

    task automatic test_fail();
        int d0;
        bit gc;
        d0 = drop_cnt;
        deliver(3'd0, 2'd1, 5'd8, 3'd6, 1'b0, 1'b1, 1'b0, gc);
        checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL fail_dropped got %0d exp 1", drop_cnt - d0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fail_valid got %0b exp 0", valid); end
        deliver(3'd0, 2'd1, 5'd8, 3'd6, 1'b1, 1'b0, 1'b0, gc);
        checks++; if ({valid, msg_hdr} !== {1'b1, 5'd8}) begin errors++; $display("FAIL fail_table_kept got %0h exp %0h", {valid, msg_hdr}, {1'b1, 5'd8}); end
        do_ack();
        deliver(3'd2, 2'd1, 5'd9, 3'd2, 1'b1, 1'b1, 1'b0, gc);
        checks++; if ({valid, msg_hdr} !== {1'b1, 5'd9}) begin errors++; $display("FAIL fail_done_wins got %0h exp %0h", {valid, msg_hdr}, {1'b1, 5'd9}); end
        do_ack();
    endtask

    task automatic test_overrun();
        int o0;
        bit gc;
        o0 = ovr_cnt;
        deliver(3'd2, 2'd1, 5'd10, 3'd0, 1'b1, 1'b0, 1'b0, gc);
        deliver(3'd2, 2'd2, 5'd11, 3'd1, 1'b1, 1'b0, 1'b0, gc);
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse got %0d exp 1", ovr_cnt - o0); end
        checks++; if ({valid, msg_type, msg_hdr} !== {1'b1, 2'd2, 5'd11}) begin errors++; $display("FAIL ovr_second got %0h exp %0h", {valid, msg_type, msg_hdr}, {1'b1, 2'd2, 5'd11}); end
        o0 = ovr_cnt;
        deliver(3'd2, 2'd1, 5'd12, 3'd3, 1'b1, 1'b0, 1'b1, gc);
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL ovr_ack_load got %0d exp 0", ovr_cnt - o0); end
        checks++; if ({valid, msg_hdr} !== {1'b1, 5'd12}) begin errors++; $display("FAIL ovr_load_wins got %0h exp %0h", {valid, msg_hdr}, {1'b1, 5'd12}); end
        do_ack();
        o0 = ovr_cnt;
        set_msg(3'd0, 2'd1, 5'd13, 3'd7);
        req = 1'b1; step(); req = 1'b0;
        step();
        set_msg(3'd1, 2'd1, 5'd14, 3'd0);
        req = 1'b1; step(); req = 1'b0;
        checks++; if ({gc_req, gc_sop, gc_id} !== {1'b1, 3'd0, 3'd7}) begin errors++; $display("FAIL ovr_capture_kept got %0h exp %0h", {gc_req, gc_sop, gc_id}, {1'b1, 3'd0, 3'd7}); end
        done = 1'b1; step(); done = 1'b0;
        step();
        checks++; if ({valid, msg_hdr, msg_sop} !== {1'b1, 5'd13, 3'd0}) begin errors++; $display("FAIL ovr_first_kept got %0h exp %0h", {valid, msg_hdr, msg_sop}, {1'b1, 5'd13, 3'd0}); end
        step();
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_req_busy got %0d exp 1", ovr_cnt - o0); end
        do_ack();
        do_ack();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_idle_ack got %0b exp 0", valid); end
    endtask

    task automatic test_clear();
        int d0, o0, s0;
        bit gc;
        deliver(3'd0, 2'd1, 5'd15, 3'd2, 1'b1, 1'b0, 1'b0, gc);
        do_ack();
        deliver(3'd1, 2'd1, 5'd16, 3'd4, 1'b1, 1'b0, 1'b0, gc);
        set_msg(3'd0, 2'd1, 5'd17, 3'd2);
        req = 1'b1; step(); req = 1'b0;
        step();
        d0 = drop_cnt; o0 = ovr_cnt; s0 = sr_cnt;
        clear = 1'b1; step(); clear = 1'b0;
        checks++; if ({gc_req, valid} !== 2'b00) begin errors++; $display("FAIL clr_outputs got %0b exp 00", {gc_req, valid}); end
        step(); step();
        checks++; if ((drop_cnt - d0) + (ovr_cnt - o0) + (sr_cnt - s0) !== 0) begin errors++; $display("FAIL clr_no_pulses got %0d exp 0", (drop_cnt - d0) + (ovr_cnt - o0) + (sr_cnt - s0)); end
        deliver(3'd0, 2'd1, 5'd18, 3'd2, 1'b1, 1'b0, 1'b0, gc);
        checks++; if ({valid, msg_hdr} !== {1'b1, 5'd18}) begin errors++; $display("FAIL clr_dup_accepted got %0h exp %0h", {valid, msg_hdr}, {1'b1, 5'd18}); end
        do_ack();
    endtask

    task automatic test_rst_midway();
        bit gc;
        deliver(3'd2, 2'd1, 5'd19, 3'd5, 1'b1, 1'b0, 1'b0, gc);
        set_msg(3'd2, 2'd1, 5'd20, 3'd5);
        req = 1'b1; step(); req = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if ({gc_req, gc_id, valid, msg_hdr} !== 10'd0) begin errors++; $display("FAIL rst_mid_outputs got %0h exp 0", {gc_req, gc_id, valid, msg_hdr}); end
        deliver(3'd2, 2'd1, 5'd21, 3'd5, 1'b1, 1'b0, 1'b0, gc);
        checks++; if ({valid, msg_hdr} !== {1'b1, 5'd21}) begin errors++; $display("FAIL rst_dup_accepted got %0h exp %0h", {valid, msg_hdr}, {1'b1, 5'd21}); end
        do_ack();
    endtask

    task automatic test_non_sop();
        int d0, hi;
        bit gc;
        deliver(3'd0, 2'd1, 5'd22, 3'd1, 1'b1, 1'b0, 1'b0, gc);
        do_ack();
        d0 = drop_cnt; hi = 0;
        set_msg(3'd4, 2'd1, 5'd24, 3'd1);
        req = 1'b1; step(); req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (gc_req === 1'b1) hi++;
        end
        checks++; if (hi !== 0) begin errors++; $display("FAIL nonsop_no_gc got %0d exp 0", hi); end
        checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL nonsop_dropped got %0d exp 1", drop_cnt - d0); end
        deliver(3'd0, 2'd1, 5'd23, 3'd1, 1'b1, 1'b0, 1'b0, gc);
        checks++; if ({valid, msg_hdr} !== {1'b1, 5'd23}) begin errors++; $display("FAIL nonsop_ids_cleared got %0h exp %0h", {valid, msg_hdr}, {1'b1, 5'd23}); end
        do_ack();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; clear = 1'b0; done = 1'b0; fail = 1'b0; ack = 1'b0;
        set_msg(3'd0, 2'd0, 5'd0, 3'd0);
        test_reset();
        test_single();
        test_duplicate();
        test_soft_reset();
        test_timeout();
        test_fail();
        test_overrun();
        test_clear();
        test_rst_midway();
        test_non_sop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prl_rx_msg_ctrl.md
PRL_RX_MSG_CTRL -- requirements
Module: prl_rx_msg_ctrl

Interface
REQ-001 SHALL have parameter GOODCRC_TO_CYC, default 8'd200: cycles allowed for TX to finish a GoodCRC.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk in 1: sole clock.
- rst in 1: reset, synchronous, active-high.
- prl_rx_parser_message_req in 1: one-cycle pulse, a parsed message is complete.
- prl_rx_parser_message_type in 2: 0 control, 1 data, 2 extended.
- prl_rx_parser_sop_type in 3: 0..2 SOP/SOP'/SOP''; 3 and above are non-SOP.
- prl_rx_parser_header_type in 5: header message type.
- prl_rx_parser_message_id in 3: header MessageID.
- prl_rx_ctrl_clear in 1: hard-reset clear from the policy engine.
- prl_rx_goodcrc_req out 1: GoodCRC transmit request to the TX path.
- prl_rx_goodcrc_sop_type out 3: SOP type for the GoodCRC.
- prl_rx_goodcrc_message_id out 3: MessageID to echo.
- prl_tx_goodcrc_done in 1: pulse, GoodCRC sent.
- prl_tx_goodcrc_fail in 1: pulse, GoodCRC not sent.
- prl_rx_msg_valid out 1: delivered message pending for the policy engine.
- prl_rx_msg_type out 2, prl_rx_msg_header_type out 5, prl_rx_msg_sop_type out 3: delivered message fields.
- pe_rx_msg_ack in 1: policy engine consumed the message.
- prl_rx_msg_dropped out 1: pulse, message discarded.
- prl_rx_msg_overrun out 1: pulse, message lost.
- prl_rx_soft_reset_det out 1: pulse, Soft_Reset accepted.

Function
REQ-003 SHALL implement FSM states IDLE, CHECK, GC_REQ and COMMIT, with a registered state.
REQ-004 IDLE: on message_req, SHALL latch sop, type, header and id into a capture register and go to CHECK.
REQ-005 CHECK (1 cycle): if the captured sop is 3 or above, SHALL pulse dropped, clear all stored IDs and go to IDLE; otherwise go to GC_REQ.
REQ-006 GC_REQ: goodcrc_req SHALL equal 1, with sop_type and message_id driven from the capture register. The outputs are decoded from the state register, so goodcrc_req rises 2 cycles after message_req.
REQ-007 GC_REQ: done SHALL go to COMMIT; fail SHALL go to IDLE and pulse dropped. If done and fail are sampled together, done wins.
REQ-008 GC_REQ timeout: an 8-bit counter clears on entry and counts each cycle. If it reaches GOODCRC_TO_CYC-1 with no done or fail, the block SHALL go to IDLE and pulse dropped. If done arrives in the timeout cycle, done wins.
REQ-009 Per-SOP stored-ID table SHALL hold 3 entries, each a valid bit plus a 3-bit ID.
REQ-010 A message is a duplicate if the entry for its sop is valid, the stored ID equals the captured id, and the message is not Soft_Reset.
REQ-011 Soft_Reset is defined as type==0 and header==5'h0D.
REQ-012 COMMIT (1 cycle), duplicate: SHALL pulse dropped, leave the table unchanged and go to IDLE.
REQ-013 COMMIT, non-duplicate: SHALL write id into table[sop] and set its valid bit. For Soft_Reset it SHALL also invalidate the other two entries and pulse soft_reset_det. It SHALL then load the output buffer and go to IDLE. Net latency: valid is high 2 cycles after done is sampled.
REQ-014 The output buffer SHALL be one entry. prl_rx_msg_valid SHALL be held until a cycle with pe_rx_msg_ack high, and deassert on the next edge.
REQ-015 Buffer load while valid=1 with no ack in the same cycle: SHALL overwrite the buffer, keep valid=1 and pulse overrun.
REQ-016 Buffer load while ack is high in the same cycle: load SHALL win, valid stays 1, no overrun.
REQ-017 message_req while the state is not IDLE SHALL be ignored and SHALL pulse overrun; the capture register is unchanged.
REQ-018 ack while valid=0 SHALL be ignored.
REQ-019 prl_rx_ctrl_clear SHALL take priority over all functional events. Next state is IDLE, goodcrc_req drops the next cycle, all stored IDs are invalidated, valid goes to 0, and no pulses are generated.
REQ-020 All pulse outputs SHALL be registered and exactly one cycle wide.

Reset
REQ-021 With rst high at a clk edge, the block SHALL enter IDLE and clear the capture register, stored-ID table, output buffer and timeout counter.
REQ-022 After reset, every output SHALL be 0, including mid-handshake (goodcrc_req falls on the next edge).

Configuration
REQ-023 Macro PRL_RX_DUP_CHECK_EN, defined: duplicate detection and the Soft_Reset invalidation per REQ-009 to REQ-013.
REQ-024 Macro PRL_RX_DUP_CHECK_EN, undefined: the stored-ID table SHALL be absent and every committed message is delivered. soft_reset_det still pulses, and dropped pulses only for non-SOP messages, fail or timeout.

Verification
REQ-025 Single message: req with sop=0, id=3, type=1, hdr=2; done 5 cycles later -> goodcrc_req high from T+2 with id=3 until done; valid high 2 cycles after done with hdr=2; ack clears valid.
REQ-026 Duplicate: repeat sop=0, id=3 -> GoodCRC still sent; dropped pulses at COMMIT; valid stays 0. Then sop=1, id=3 -> delivered, because tables are per SOP.
REQ-027 Soft_Reset: table holds sop0 id=3 and sop1 id=5; receive sop0 type=0, hdr=0x0D, id=3 -> delivered, soft_reset_det pulses, sop1 entry invalidated; a following sop1 id=5 is delivered.
REQ-028 Timeout and fail: GOODCRC_TO_CYC=10 with no done -> goodcrc_req high for exactly 10 cycles, then dropped; separately, fail in GC_REQ -> dropped, table unchanged.
REQ-029 Overrun: two messages delivered with no ack -> overrun pulses and the buffer holds the second hdr. A message_req during GC_REQ -> overrun, ignored.
REQ-030 Clear/reset: assert prl_rx_ctrl_clear or rst during GC_REQ -> goodcrc_req low next cycle, valid=0; a prior duplicate id is accepted afterwards.
